regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//  Arbitrates the single register-file write port between the pipeline writeback (WB) stage and the
//  multi-cycle mul/div unit (MDU); registered rf_* outputs feed regfile waddr/wdata/we.
//  WB always has priority; a 1-entry buffer holds the MDU result until a free write slot appears,
//  and a starvation counter forces a pipeline stall so the buffered write always drains.
//  Also keeps a 32-bit busy scoreboard of MDU destinations and forwards buffered/in-flight data to the regfile match ports.
// PARAMETERS
//  DATA_W        32  register data width
//  STARVE_LIMIT  4   consecutive lost arbitration cycles before stall_req (>=1); counter width $clog2(STARVE_LIMIT+1)
// PORTS
//  clk             in   1       clock; all state updates on posedge
//  rst_n           in   1       synchronous reset, active low
//  wb_we           in   1       WB write request (no backpressure; must be 0 whenever stall_req=1)
//  wb_waddr        in   5       WB destination
//  wb_wdata        in   DATA_W  WB data
//  mdu_issue       in   1       MDU operation issued; marks mdu_issue_addr busy
//  mdu_issue_addr  in   5       destination of issued MDU op
//  mdu_valid       in   1       MDU result valid
//  mdu_addr        in   5       MDU result destination
//  mdu_data        in   DATA_W  MDU result
//  mdu_ready       out  1       buffer can accept MDU result this cycle
//  stall_req       out  1       freeze pipeline WB; buffered MDU write owns the port this cycle
//  rf_we           out  1       regfile write enable (registered)
//  rf_waddr        out  5       regfile write address (registered)
//  rf_wdata        out  DATA_W  regfile write data (registered)
//  raddr1/raddr2   in   5       decode-stage read addresses
//  busy1/busy2     out  1       read address has MDU result outstanding (not yet buffered)
//  match_1/match_2 out  1       forwarding hit for raddr1/raddr2
//  match_data1/2   out  DATA_W  forwarded data
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): buf_v=0, busy[31:0]=0, cnt=0, state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0;
//   mdu_ready forced 0 and stall_req=0 while rst_n=0. Reset mid-operation discards buffered result and busy bits.
//  wb_req = wb_we && wb_waddr!=0 (writes to r0 are dropped, never occupy the port).
//  Grant each cycle: state==STALL -> buffer; else wb_req -> WB; else buf_v -> buffer; else none.
//  rf_* registered from the granted source: 1-cycle latency, rf_we=0 when no grant.
//  mdu_ready = !buf_v || grant_buf (combinational); accept = mdu_valid && mdu_ready; accept with mdu_addr==0 is discarded.
//  Accept and drain in the same cycle: old entry goes to rf_*, new entry loads buffer, cnt cleared.
//  FSM (stall_req = state==STALL, Moore):
//   IDLE : buf_v=0. accept -> WAIT (cnt=0).
//   WAIT : buf_v=1. grant_buf -> IDLE (or WAIT with cnt=0 if accept); else cnt++, and cnt==STARVE_LIMIT-1 -> STALL.
//   STALL: buffer written unconditionally, stall_req=1; -> IDLE (or WAIT, cnt=0, if accept).
//  wb_req while stall_req=1 is a protocol violation (bench asserts); arbiter still writes the buffer.
//  Scoreboard: mdu_issue && addr!=0 sets busy[addr]; accept clears busy[mdu_addr]; same-cycle set and clear
//   of same register -> set wins. WB writes never modify busy. busyN = busy[raddrN] (raddrN==0 -> 0).
//  Forwarding (combinational), raddrN!=0 only, priority: buf_v && buf_addr==raddrN -> buf_data;
//   else rf_we && rf_waddr==raddrN -> rf_wdata; else match_N=0, match_dataN=0.
// TESTING
//  Reset: rst_n=0 2 cycles with mdu_valid=1 -> rf_we=0, mdu_ready=0, busy all 0; release -> mdu_ready=1.
//  Idle port: mdu_valid r5=0x1234, wb_we=0 -> next cycle buffered; cycle after, rf_we=1 rf_waddr=5 rf_wdata=0x1234.
//  Conflict: MDU r3=0xAA buffered, wb_we=1 r7 every cycle -> stall_req=1 after STARVE_LIMIT lost cycles; r3 written that cycle.
//  Scoreboard: mdu_issue r9 -> busy1=1 for raddr1=9 until accept; issue+accept r9 same cycle -> busy stays 1.
//  Forwarding: buffer r4=0x55, rf_* writing r4=0x11, raddr1=4 -> match_1=1 match_data1=0x55; raddr2=0 -> match_2=0.
//  Back-to-back: mdu_valid 3 consecutive cycles, wb idle -> 1 result/cycle to rf_*, mdu_ready stays 1, r0 result dropped.

Source files
------------

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter. The pipeline writeback stage always has
// priority. A one-entry buffer holds an MDU result until the port is free, and
// a starvation counter stalls the pipeline so that the buffered write drains.
// The block also keeps a busy scoreboard of outstanding MDU destinations and
// forwards buffered or in-flight write data to the decode read ports.
module regfile_wport_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [4:0]        wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              mdu_issue,
    input  logic [4:0]        mdu_issue_addr,
    input  logic              mdu_valid,
    input  logic [4:0]        mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              stall_req,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              match_1,
    output logic              match_2,
    output logic [DATA_W-1:0] match_data1,
    output logic [DATA_W-1:0] match_data2
);

    localparam int unsigned      CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic [31:0]       busy_q, busy_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic wb_req, buf_v, stall_st, grant_buf, grant_wb, accept, load;

    // Arbitration: a stalled pipeline hands the port to the buffer, otherwise WB wins.
    always_comb begin
        wb_req    = wb_we && (wb_waddr != 5'd0);
        buf_v     = (state_q != ST_IDLE);
        stall_st  = (state_q == ST_STALL);
        grant_buf = stall_st || (buf_v && !wb_req);
        grant_wb  = wb_req && !stall_st;
        mdu_ready = rst_n && (!buf_v || grant_buf);
        stall_req = rst_n && stall_st;
        accept    = mdu_valid && mdu_ready;
        // Results for r0 are accepted but never stored.
        load      = accept && (mdu_addr != 5'd0);
    end

    // Buffer occupancy FSM and starvation counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (grant_buf) begin
                    state_d = load ? ST_WAIT : ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STALL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STALL: begin
                state_d = load ? ST_WAIT : ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Buffer payload, scoreboard and registered write port.
    always_comb begin
        buf_addr_d = load ? mdu_addr : buf_addr_q;
        buf_data_d = load ? mdu_data : buf_data_q;

        busy_d = busy_q;
        if (load) begin
            busy_d[mdu_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle re-issue keeps the register busy.
        if (mdu_issue && (mdu_issue_addr != 5'd0)) begin
            busy_d[mdu_issue_addr] = 1'b1;
        end

        rf_we_d    = grant_buf || grant_wb;
        rf_waddr_d = 5'd0;
        rf_wdata_d = '0;
        if (grant_buf) begin
            rf_waddr_d = buf_addr_q;
            rf_wdata_d = buf_data_q;
        end else if (grant_wb) begin
            rf_waddr_d = wb_waddr;
            rf_wdata_d = wb_wdata;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            buf_addr_q <= 5'd0;
            buf_data_q <= '0;
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Scoreboard lookup and forwarding; the buffered value is newer than the one in flight.
    always_comb begin
        busy1       = (raddr1 != 5'd0) && busy_q[raddr1];
        busy2       = (raddr2 != 5'd0) && busy_q[raddr2];
        match_1     = 1'b0;
        match_2     = 1'b0;
        match_data1 = '0;
        match_data2 = '0;
        if (raddr1 != 5'd0) begin
            if (buf_v && (buf_addr_q == raddr1)) begin
                match_1     = 1'b1;
                match_data1 = buf_data_q;
            end else if (rf_we_q && (rf_waddr_q == raddr1)) begin
                match_1     = 1'b1;
                match_data1 = rf_wdata_q;
            end
        end
        if (raddr2 != 5'd0) begin
            if (buf_v && (buf_addr_q == raddr2)) begin
                match_2     = 1'b1;
                match_data2 = buf_data_q;
            end else if (rf_we_q && (rf_waddr_q == raddr2)) begin
                match_2     = 1'b1;
                match_data2 = rf_wdata_q;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_wport_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_addr;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready, stall_req, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1, raddr2;
    logic        busy1, busy2, match_1, match_2;
    logic [31:0] match_data1, match_data2;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_wport_arbiter #(.DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .stall_req(stall_req),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raddr1(raddr1), .raddr2(raddr2), .busy1(busy1), .busy2(busy2),
        .match_1(match_1), .match_2(match_2),
        .match_data1(match_data1), .match_data2(match_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a pending MDU result plus how many cycles it has waited.
    bit        m_sync = 0;
    bit        m_buf_v = 0;
    bit [4:0]  m_buf_a = 0;
    bit [31:0] m_buf_d = 0;
    int        m_lost = 0;
    bit [31:0] m_busy = 0;
    bit        m_rf_we = 0;
    bit [4:0]  m_rf_a = 0;
    bit [31:0] m_rf_d = 0;
    // next-state copies, computed mid-cycle and applied on the clock edge
    bit        n_buf_v, n_rf_we;
    bit [4:0]  n_buf_a, n_rf_a;
    bit [31:0] n_buf_d, n_rf_d, n_busy;
    int        n_lost;

    function automatic bit [32:0] fwd(input bit [4:0] ra);
        if (ra == 0) return 33'd0;
        if (m_buf_v && m_buf_a == ra) return {1'b1, m_buf_d};
        if (m_rf_we && m_rf_a == ra) return {1'b1, m_rf_d};
        return 33'd0;
    endfunction

    // Compare process: evaluate the model against the DUT, then prepare its next state.
    always @(negedge clk) begin
        bit wb_req, stall, buf_wins, ready, acc;
        bit [32:0] f1, f2;
        wb_req   = wb_we && wb_waddr != 0;
        stall    = rst_n && m_buf_v && m_lost >= LIMIT;
        buf_wins = m_buf_v && (m_lost >= LIMIT || !wb_req);
        ready    = rst_n && (!m_buf_v || buf_wins);
        acc      = mdu_valid && ready && mdu_addr != 0;
        f1 = fwd(raddr1);
        f2 = fwd(raddr2);
        if (m_sync) begin
            chk("m_rf_we", 32'(rf_we), 32'(m_rf_we));
            if (m_rf_we) begin
                chk("m_rf_waddr", 32'(rf_waddr), 32'(m_rf_a));
                chk("m_rf_wdata", rf_wdata, m_rf_d);
            end
            chk("m_stall_req", 32'(stall_req), 32'(stall));
            chk("m_mdu_ready", 32'(mdu_ready), 32'(ready));
            chk("m_busy1", 32'(busy1), 32'(raddr1 != 0 && m_busy[raddr1]));
            chk("m_busy2", 32'(busy2), 32'(raddr2 != 0 && m_busy[raddr2]));
            chk("m_match_1", 32'(match_1), 32'(f1[32]));
            chk("m_match_data1", match_data1, f1[31:0]);
            chk("m_match_2", 32'(match_2), 32'(f2[32]));
            chk("m_match_data2", match_data2, f2[31:0]);
            if (stall_req && wb_req) begin
                n_fail++;
                $display("FAIL protocol: wb_we to r%0d while stall_req=1", wb_waddr);
            end
        end
        if (!rst_n) begin
            n_buf_v = 0; n_buf_a = 0; n_buf_d = 0; n_lost = 0; n_busy = 0;
            n_rf_we = 0; n_rf_a = 0; n_rf_d = 0;
        end else begin
            n_rf_we = buf_wins || wb_req;
            n_rf_a  = buf_wins ? m_buf_a : (wb_req ? wb_waddr : 5'd0);
            n_rf_d  = buf_wins ? m_buf_d : (wb_req ? wb_wdata : 32'd0);
            n_buf_a = m_buf_a; n_buf_d = m_buf_d;
            if (acc) begin
                n_buf_v = 1; n_buf_a = mdu_addr; n_buf_d = mdu_data; n_lost = 0;
            end else if (buf_wins) begin
                n_buf_v = 0; n_lost = 0;
            end else begin
                n_buf_v = m_buf_v; n_lost = m_buf_v ? m_lost + 1 : 0;
            end
            n_busy = m_busy;
            if (acc) n_busy[mdu_addr] = 1'b0;
            if (mdu_issue && mdu_issue_addr != 0) n_busy[mdu_issue_addr] = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) m_sync = 1;
        m_buf_v = n_buf_v; m_buf_a = n_buf_a; m_buf_d = n_buf_d; m_lost = n_lost;
        m_busy = n_busy; m_rf_we = n_rf_we; m_rf_a = n_rf_a; m_rf_d = n_rf_d;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        mdu_issue = 0; mdu_issue_addr = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0; raddr1 = 9; raddr2 = 5;
        mdu_valid = 1; mdu_addr = 5; mdu_data = 32'h1;
        // Reset held two cycles with a pending MDU result
        tick(); tick();
        #3;
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_mdu_ready", 32'(mdu_ready), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_busy2", 32'(busy2), 0);
        rst_n = 1; idle_inputs();
        #1;
        chk("rel_mdu_ready", 32'(mdu_ready), 1);
        tick();

        // Idle port: r5 buffered, then written
        mdu_valid = 1; mdu_addr = 5; mdu_data = 32'h1234; raddr1 = 5;
        #3 chk("idle_ready", 32'(mdu_ready), 1);
        tick(); idle_inputs();
        #3 chk("idle_buf_match", 32'(match_1), 1);
        chk("idle_buf_data", match_data1, 32'h1234);
        chk("idle_rf_we0", 32'(rf_we), 0);
        tick();
        #3 chk("idle_rf_we", 32'(rf_we), 1);
        chk("idle_rf_waddr", 32'(rf_waddr), 5);
        chk("idle_rf_wdata", rf_wdata, 32'h1234);

        // Conflict: WB hogs the port until the starvation stall
        mdu_valid = 1; mdu_addr = 3; mdu_data = 32'hAA;
        wb_we = 1; wb_waddr = 7; wb_wdata = 32'h77;
        tick(); mdu_valid = 0;
        for (int i = 0; i < LIMIT; i++) begin
            #3 chk("conf_no_stall", 32'(stall_req), 0);
            tick();
        end
        wb_we = 0;
        #3 chk("conf_stall", 32'(stall_req), 1);
        chk("conf_ready_in_stall", 32'(mdu_ready), 1);
        tick();
        #3 chk("conf_rf_waddr", 32'(rf_waddr), 3);
        chk("conf_rf_wdata", rf_wdata, 32'hAA);
        chk("conf_rf_we", 32'(rf_we), 1);
        chk("conf_stall_off", 32'(stall_req), 0);

        // Scoreboard
        idle_inputs(); raddr1 = 9; raddr2 = 0;
        mdu_issue = 1; mdu_issue_addr = 9;
        tick(); mdu_issue = 0;
        #3 chk("sb_busy_set", 32'(busy1), 1);
        tick();
        #3 chk("sb_busy_hold", 32'(busy1), 1);
        mdu_issue = 1; mdu_issue_addr = 9;
        mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h99;
        tick(); mdu_issue = 0; mdu_valid = 0;
        #3 chk("sb_set_wins", 32'(busy1), 1);
        mdu_valid = 1; mdu_addr = 9; mdu_data = 32'h9A;
        tick(); mdu_valid = 0;
        #3 chk("sb_cleared", 32'(busy1), 0);
        tick();

        // Forwarding: buffered r4 beats in-flight r4
        mdu_valid = 1; mdu_addr = 4; mdu_data = 32'h55;
        wb_we = 1; wb_waddr = 4; wb_wdata = 32'h11;
        tick(); idle_inputs(); raddr1 = 4; raddr2 = 0;
        #3 chk("fwd_match1", 32'(match_1), 1);
        chk("fwd_data1", match_data1, 32'h55);
        chk("fwd_match2", 32'(match_2), 0);
        chk("fwd_data2", match_data2, 0);
        tick();

        // Back-to-back MDU results, one of them to r0
        mdu_valid = 1; mdu_addr = 10; mdu_data = 32'hA0;
        #3 chk("b2b_ready0", 32'(mdu_ready), 1);
        tick(); mdu_addr = 0; mdu_data = 32'hB0;
        #3 chk("b2b_ready1", 32'(mdu_ready), 1);
        tick(); mdu_addr = 11; mdu_data = 32'hC0;
        #3 chk("b2b_ready2", 32'(mdu_ready), 1);
        chk("b2b_rf_waddr10", 32'(rf_waddr), 10);
        chk("b2b_rf_wdata10", rf_wdata, 32'hA0);
        tick(); mdu_valid = 0;
        #3 chk("b2b_r0_dropped", 32'(rf_we), 0);
        tick();
        #3 chk("b2b_rf_waddr11", 32'(rf_waddr), 11);
        chk("b2b_rf_wdata11", rf_wdata, 32'hC0);

        // Randomized traffic with occasional mid-operation reset
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n          = ($urandom_range(0, 149) != 0);
            wb_we          = (m_buf_v && m_lost >= LIMIT) ? 1'b0 : 1'($urandom_range(0, 1));
            wb_waddr       = 5'($urandom_range(0, 7));
            wb_wdata       = $urandom;
            mdu_issue      = ($urandom_range(0, 9) < 3);
            mdu_issue_addr = 5'($urandom_range(0, 7));
            mdu_valid      = ($urandom_range(0, 9) < 4);
            mdu_addr       = 5'($urandom_range(0, 7));
            mdu_data       = $urandom;
            raddr1         = 5'($urandom_range(0, 7));
            raddr2         = 5'($urandom_range(0, 7));
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
